// File: rtl/rr_sched_pkg.sv
// rr_sched_pkg: state encodings and the round-robin pick function shared by the scheduler
package rr_sched_pkg;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GRANT = 2'b01;
  localparam logic [1:0] ST_TURN  = 2'b10;
  localparam int MAX_N = 8;
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;
  // first requester found searching last_id+1, last_id+2, ... modulo n; last_id itself is tried last
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req, input logic [2:0] last_id, input int n);
    pick_t p;
    int c;
    p = '0;
    for (int k = 1; k <= MAX_N; k++) begin
      c = (int'(last_id) + k) % n;
      if (k <= n && !p.valid && req[c]) begin
        p.valid = 1'b1;
        p.idx   = 3'(c);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotate-and-priority-encode of req starting after last_id
module rr_priority_pick
  import rr_sched_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last_id,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_idx
);
  pick_t w_pick;
  assign w_pick  = rr_pick(MAX_N'(i_req), 3'(i_last_id), N_REQ);
  assign o_valid = w_pick.valid;
  assign o_idx   = ID_W'(w_pick.idx);
endmodule

// File: rtl/rr_grant_sched.sv
// rr_grant_sched: round-robin owner scheduler with bounded hold and one-cycle turnaround
module rr_grant_sched
  import rr_sched_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int MAX_HOLD = 4,
  parameter int ID_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic             preempt,
  output logic [1:0]       state_out
);
  localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);
  logic [1:0]       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_grant;
  logic [ID_W-1:0]  r_grant_id, r_last_id, w_pick_id;
  logic [HW-1:0]    r_hold_cnt;
  logic             r_preempt, w_pick_valid, w_in_grant, w_release, w_preempt, w_ok;
  assign w_in_grant = r_state == ST_GRANT;
  rr_priority_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .i_req     (req),
    .i_last_id (r_last_id),
    .o_valid   (w_pick_valid),
    .o_idx     (w_pick_id)
  );
  // next state: release beats preempt, and preempt needs a full hold window with someone waiting
  always_comb begin
    w_release   = w_in_grant && ((|(done & r_grant)) || !(|(req & r_grant)));
    w_preempt   = w_in_grant && !w_release && (r_hold_cnt == HOLD_TOP) && (|(req & ~r_grant));
    w_state_nxt = (r_state == ST_IDLE || r_state == ST_TURN) ? (w_pick_valid ? ST_GRANT : ST_IDLE) :
                  w_in_grant ? ((w_release || w_preempt) ? ST_TURN : ST_GRANT) : ST_IDLE;
  end
  // state and owner registers; a new owner is loaded only when entering GRANT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_hold_cnt <= '0;
      r_last_id  <= ID_W'(N_REQ - 1);
      r_preempt  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_preempt <= w_preempt;
      if (w_state_nxt == ST_GRANT && !w_in_grant) begin
        r_grant    <= N_REQ'(1) << w_pick_id;
        r_grant_id <= w_pick_id;
        r_hold_cnt <= '0;
        r_last_id  <= w_pick_id;
      end else if (w_state_nxt == ST_GRANT) begin
        r_hold_cnt <= (r_hold_cnt == HOLD_TOP) ? r_hold_cnt : r_hold_cnt + HW'(1);
      end else begin
        r_grant    <= '0;
        r_grant_id <= '0;
        r_hold_cnt <= '0;
      end
    end
  end
  // outputs forced quiet if the state register ever holds the unused encoding
  always_comb begin
    w_ok      = r_state != 2'b11;
    grant     = w_ok ? r_grant : '0;
    grant_id  = w_ok ? r_grant_id : '0;
    busy      = w_in_grant;
    preempt   = w_ok ? r_preempt : 1'b0;
    state_out = r_state;
  end
endmodule

// File: tb/tb_rr_grant_sched.sv
// tb_rr_grant_sched: directed vectors with hand-computed expectations for rr_grant_sched
module tb_rr_grant_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = '0;
  logic [2:0] done = '0;
  logic [2:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       preempt;
  logic [1:0] state_out;
  int checks = 0;
  int errors = 0;

  rr_grant_sched #(.N_REQ(3), .MAX_HOLD(4), .ID_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_id  (grant_id),
    .busy      (busy),
    .preempt   (preempt),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got grant,id,busy,pre,st=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic ex(input string tag, input logic [2:0] g, input logic [1:0] id, input logic b,
                    input logic p, input logic [1:0] s);
    @(negedge clk);
    chk(tag, {grant, grant_id, busy, preempt, state_out}, {g, id, b, p, s});
  endtask

  initial begin
    ex("reset", 3'b000, 2'd0, 0, 0, 2'b00);
    rst_n = 1'b1;
    ex("idle_noreq", 3'b000, 2'd0, 0, 0, 2'b00);
    req = 3'b111;
    ex("first_g0", 3'b001, 2'd0, 1, 0, 2'b01);
    ex("g0_hold", 3'b001, 2'd0, 1, 0, 2'b01);
    done = 3'b001;
    ex("turn_done0", 3'b000, 2'd0, 0, 0, 2'b10);
    done = 3'b000;
    req = 3'b110;
    ex("g1", 3'b010, 2'd1, 1, 0, 2'b01);
    done = 3'b010;
    ex("turn_done1", 3'b000, 2'd0, 0, 0, 2'b10);
    done = 3'b000;
    ex("g2", 3'b100, 2'd2, 1, 0, 2'b01);
    req = 3'b011;
    ex("turn_drop2", 3'b000, 2'd0, 0, 0, 2'b10);
    for (int i = 0; i < 4; i++) ex("hold_g0", 3'b001, 2'd0, 1, 0, 2'b01);
    ex("preempt0", 3'b000, 2'd0, 0, 1, 2'b10);
    for (int i = 0; i < 4; i++) ex("hold_g1", 3'b010, 2'd1, 1, 0, 2'b01);
    ex("preempt1", 3'b000, 2'd0, 0, 1, 2'b10);
    ex("back_g0", 3'b001, 2'd0, 1, 0, 2'b01);
    req = 3'b100;
    ex("turn_sole", 3'b000, 2'd0, 0, 0, 2'b10);
    for (int i = 0; i < 9; i++) ex("sole_g2", 3'b100, 2'd2, 1, 0, 2'b01);
    req = 3'b101;
    ex("preempt_sat", 3'b000, 2'd0, 0, 1, 2'b10);
    for (int i = 0; i < 4; i++) ex("g0_again", 3'b001, 2'd0, 1, 0, 2'b01);
    req = 3'b100;
    done = 3'b001;
    ex("release_wins", 3'b000, 2'd0, 0, 0, 2'b10);
    done = 3'b000;
    ex("g2_after_rel", 3'b100, 2'd2, 1, 0, 2'b01);
    req = 3'b010;
    ex("turn_to_g1", 3'b000, 2'd0, 0, 0, 2'b10);
    ex("g1_again", 3'b010, 2'd1, 1, 0, 2'b01);
    rst_n = 1'b0;
    req = 3'b111;
    done = 3'b010;
    ex("reset_mid", 3'b000, 2'd0, 0, 0, 2'b00);
    rst_n = 1'b1;
    done = 3'b000;
    ex("post_reset_g0", 3'b001, 2'd0, 1, 0, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_grant_sched.md
Name: rr_grant_sched

Overview:
- Round-robin scheduler that shares one FSM-driven datapath resource between N_REQ requesters.
- Accepts per-requester request/done lines and issues a registered one-hot grant, with bounded hold time and a one-cycle turnaround between owners.
- Sits in front of the shared FSM; its grant/grant_id drive that FSM's input select.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- MAX_HOLD, 4, max consecutive cycles one owner keeps grant while others wait (>=1)
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= N_REQ

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- req  in  N_REQ  per-requester request, level, held until granted or withdrawn
- done  in  N_REQ  per-requester release strobe, only meaningful for current owner
- grant  out  N_REQ  one-hot grant, registered; all-zero when no owner
- grant_id  out  ID_W  index of current owner; 0 when grant==0
- busy  out  1  high in GRANT state
- preempt  out  1  one-cycle pulse when owner is forcibly revoked by MAX_HOLD
- state_out  out  2  current state encoding, for debug/observation

Behaviour:
- State encoding: IDLE=2'b00, GRANT=2'b01, TURN=2'b10; 2'b11 illegal -> next state IDLE, all outputs 0.
- Reset (rst_n==0 at posedge): state=IDLE, grant=0, grant_id=0, busy=0, preempt=0, hold_cnt=0, last_id=N_REQ-1 (so requester 0 has first priority).
- Arbitration: winner = first i with req[i]==1 searching last_id+1, last_id+2, ... modulo N_REQ. Non-requesters and done bits of non-owners are ignored.
- IDLE:
  - If any req: next state GRANT, grant/grant_id load winner, hold_cnt=0, last_id=winner.
  - Latency req->grant = 1 cycle.
  - Else stay IDLE.
- GRANT (busy=1):
  - Release: done[owner]==1 or req[owner]==0 -> TURN; grant cleared on the same edge.
  - Preempt: otherwise, if hold_cnt==MAX_HOLD-1 and any other req pending -> TURN, preempt=1 for exactly that cycle (registered with the transition).
  - Otherwise stay; hold_cnt increments, saturating at MAX_HOLD-1 while no others pending.
  - If release and preempt conditions coincide, treat as release: preempt stays 0.
- TURN (grant=0, busy=0, exactly 1 cycle):
  - If any req: GRANT with new winner via round-robin from last_id. The revoked owner may win again only if it is the sole requester.
  - Else IDLE.
- preempt is 0 in every cycle except the first TURN cycle following a forced revoke.
- grant is always one-hot or zero; never two bits set.
- Reset mid-grant: next cycle grant=0 regardless of req/done.

Decomposition:
- Shared package rr_sched_pkg: state encoding constants (ST_IDLE, ST_GRANT, ST_TURN) and function rr_pick(req, last_id) returning winner index and valid.
- One natural sub-module: rr_priority_pick (combinational rotate-and-priority-encode of req from last_id+1); the FSM, hold counter and output registers live in rr_grant_sched.

Test Plan:
- Reset then req=3'b111 at cycle 0 -> cycle 1 grant=3'b001, grant_id=0, busy=1, state_out=01.
- Owner 0 asserts done after 2 cycles with req=3'b110 -> 1 cycle grant=0 (TURN), then grant=3'b010, then on next release grant=3'b100.
- req=3'b011 held constant, no done, MAX_HOLD=4 -> owner 0 holds 4 cycles, preempt=1 for one cycle with grant=0, then grant=3'b010 for 4 cycles, preempt, back to 3'b001.
- Sole requester req=3'b100 held, no done -> grant=3'b100 indefinitely, preempt never asserts, hold_cnt saturates at 3.
- Owner drops req and done coincides with hold_cnt==MAX_HOLD-1 and others pending -> TURN with preempt=0.
- rst_n=0 for one cycle while grant=3'b010 -> next cycle grant=0, state_out=00; first grant after release goes to requester 0 if requesting.
